// File: rtl/bus_encode_burst.sv
// Command-to-byte-stream framer: 0x55 header, address bytes, length, write data.
// Optional trailing checksum byte when BUS_ENCODE_BURST_CKSUM_EN is defined.
module bus_encode_burst #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sink_stb,
    output logic              sink_ack,
    input  logic              sink_wr,
    input  logic [ADDR_W-1:0] sink_a,
    input  logic [7:0]        sink_len,
    input  logic              wdat_stb,
    output logic              wdat_ack,
    input  logic [7:0]        wdat_d,
    output logic              source_stb,
    input  logic              source_ack,
    output logic [7:0]        source_d,
    output logic              source_last,
    output logic              busy,
    output logic              err_len
);

    localparam int unsigned NAB  = (ADDR_W + 2 + 7) / 8;
    localparam int unsigned AF_W = NAB * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_ADDR,
        S_LEN,
        S_DFETCH,
        S_DATA
`ifdef BUS_ENCODE_BURST_CKSUM_EN
        , S_CKSUM
`endif
    } state_t;

    state_t            state_q;
    logic              wr_q;
    logic [7:0]        len_q;
    logic [AF_W-1:0]   af_q;
    logic [7:0]        cnt_q;
    logic              sink_ack_q;
    logic              wdat_ack_q;
    logic              source_stb_q;
    logic [7:0]        source_d_q;
    logic              source_last_q;
    logic              busy_q;
    logic              err_len_q;
`ifdef BUS_ENCODE_BURST_CKSUM_EN
    logic [7:0]        cksum_q;
    logic [7:0]        cksum_d;
`endif

    logic              xfer;
    logic [AF_W-1:0]   af_d;
    logic [8:0]        len_p1;
    logic              reject;

    assign xfer   = source_stb_q && source_ack;
    assign len_p1 = 9'(sink_len) + 9'd1;
    assign reject = len_p1 > 9'(MAX_LEN);

    // Address field: {wr, 0, zero-extended address}, shifted out MSB first
    always_comb begin
        af_d           = AF_W'(sink_a);
        af_d[AF_W-1]   = sink_wr;
    end

`ifdef BUS_ENCODE_BURST_CKSUM_EN
    assign cksum_d = cksum_q + source_d_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_q          <= 1'b0;
            len_q         <= 8'h00;
            af_q          <= '0;
            cnt_q         <= 8'h00;
            sink_ack_q    <= 1'b0;
            wdat_ack_q    <= 1'b0;
            source_stb_q  <= 1'b0;
            source_d_q    <= 8'h00;
            source_last_q <= 1'b0;
            busy_q        <= 1'b0;
            err_len_q     <= 1'b0;
`ifdef BUS_ENCODE_BURST_CKSUM_EN
            cksum_q       <= 8'h00;
`endif
        end else begin
            sink_ack_q <= 1'b0;
            wdat_ack_q <= 1'b0;
            err_len_q  <= 1'b0;
`ifdef BUS_ENCODE_BURST_CKSUM_EN
            if (xfer && state_q != S_CKSUM) begin
                cksum_q <= cksum_d;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    // Skipping the cycle after an ack keeps sink_ack a single pulse
                    if (sink_stb && !sink_ack_q) begin
                        sink_ack_q <= 1'b1;
                        wr_q       <= sink_wr;
                        len_q      <= sink_len;
                        af_q       <= af_d;
                        cnt_q      <= 8'h00;
`ifdef BUS_ENCODE_BURST_CKSUM_EN
                        cksum_q    <= 8'h00;
`endif
                        if (reject) begin
                            err_len_q <= 1'b1;
                        end else begin
                            state_q       <= S_HEADER;
                            busy_q        <= 1'b1;
                            source_stb_q  <= 1'b1;
                            source_d_q    <= 8'h55;
                            source_last_q <= 1'b0;
                        end
                    end
                end
                S_HEADER: begin
                    if (xfer) begin
                        source_d_q <= af_q[AF_W-1 -: 8];
                        af_q       <= af_q << 8;
                        cnt_q      <= 8'h00;
                        state_q    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (xfer) begin
                        if (cnt_q == 8'(NAB - 1)) begin
                            source_d_q <= len_q;
                            cnt_q      <= 8'h00;
                            state_q    <= S_LEN;
`ifndef BUS_ENCODE_BURST_CKSUM_EN
                            source_last_q <= !wr_q;
`endif
                        end else begin
                            source_d_q <= af_q[AF_W-1 -: 8];
                            af_q       <= af_q << 8;
                            cnt_q      <= cnt_q + 8'd1;
                        end
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        if (wr_q) begin
                            source_stb_q <= 1'b0;
                            state_q      <= S_DFETCH;
                        end else begin
`ifdef BUS_ENCODE_BURST_CKSUM_EN
                            source_d_q    <= cksum_d;
                            source_last_q <= 1'b1;
                            state_q       <= S_CKSUM;
`else
                            source_stb_q  <= 1'b0;
                            source_last_q <= 1'b0;
                            busy_q        <= 1'b0;
                            state_q       <= S_IDLE;
`endif
                        end
                    end
                end
                S_DFETCH: begin
                    if (wdat_stb) begin
                        wdat_ack_q   <= 1'b1;
                        source_d_q   <= wdat_d;
                        source_stb_q <= 1'b1;
                        state_q      <= S_DATA;
`ifndef BUS_ENCODE_BURST_CKSUM_EN
                        source_last_q <= (cnt_q == len_q);
`endif
                    end
                end
                S_DATA: begin
                    // cnt_q indexes the byte on the bus, so it never exceeds 255
                    if (xfer) begin
                        if (cnt_q == len_q) begin
`ifdef BUS_ENCODE_BURST_CKSUM_EN
                            source_d_q    <= cksum_d;
                            source_last_q <= 1'b1;
                            state_q       <= S_CKSUM;
`else
                            source_stb_q  <= 1'b0;
                            source_last_q <= 1'b0;
                            busy_q        <= 1'b0;
                            state_q       <= S_IDLE;
`endif
                        end else begin
                            cnt_q        <= cnt_q + 8'd1;
                            source_stb_q <= 1'b0;
                            state_q      <= S_DFETCH;
                        end
                    end
                end
`ifdef BUS_ENCODE_BURST_CKSUM_EN
                S_CKSUM: begin
                    if (xfer) begin
                        source_stb_q  <= 1'b0;
                        source_last_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sink_ack    = sink_ack_q;
    assign wdat_ack    = wdat_ack_q;
    assign source_stb  = source_stb_q;
    assign source_d    = source_d_q;
    assign source_last = source_last_q;
    assign busy        = busy_q;
    assign err_len     = err_len_q;

endmodule

// File: tb/tb_bus_encode_burst.sv
// Directed bench for bus_encode_burst: default instance plus an ADDR_W=22 / MAX_LEN=256 instance.
module tb_bus_encode_burst;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        sink_stb;
    logic        sink_wr;
    logic [31:0] sink_a;
    logic [7:0]  sink_len;
    logic        wdat_stb;
    logic [7:0]  wdat_d;
    logic        source_ack;

    logic        a_sink_ack, a_wdat_ack, a_source_stb, a_source_last, a_busy, a_err_len;
    logic [7:0]  a_source_d;
    logic        b_sink_ack, b_wdat_ack, b_source_stb, b_source_last, b_busy, b_err_len;
    logic [7:0]  b_source_d;

    logic        sink_ack, wdat_ack, source_stb, source_last, busy, err_len;
    logic [7:0]  source_d;

    int          n_tests;
    int          n_fail;
    logic [7:0]  got_q[$];
    logic [7:0]  wdat_arr[$];
    int          n_wack;
    int          n_sack;
    int          bubbles;
    int          last_idx;

    bus_encode_burst #(.ADDR_W(14), .MAX_LEN(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .sink_stb(sink_stb && !sel), .sink_ack(a_sink_ack),
        .sink_wr(sink_wr), .sink_a(sink_a[13:0]), .sink_len(sink_len),
        .wdat_stb(wdat_stb && !sel), .wdat_ack(a_wdat_ack), .wdat_d(wdat_d),
        .source_stb(a_source_stb), .source_ack(source_ack && !sel),
        .source_d(a_source_d), .source_last(a_source_last),
        .busy(a_busy), .err_len(a_err_len)
    );

    bus_encode_burst #(.ADDR_W(22), .MAX_LEN(256)) u_dut_b (
        .clk(clk), .rst(rst),
        .sink_stb(sink_stb && sel), .sink_ack(b_sink_ack),
        .sink_wr(sink_wr), .sink_a(sink_a[21:0]), .sink_len(sink_len),
        .wdat_stb(wdat_stb && sel), .wdat_ack(b_wdat_ack), .wdat_d(wdat_d),
        .source_stb(b_source_stb), .source_ack(source_ack && sel),
        .source_d(b_source_d), .source_last(b_source_last),
        .busy(b_busy), .err_len(b_err_len)
    );

    assign sink_ack    = sel ? b_sink_ack    : a_sink_ack;
    assign wdat_ack    = sel ? b_wdat_ack    : a_wdat_ack;
    assign source_stb  = sel ? b_source_stb  : a_source_stb;
    assign source_last = sel ? b_source_last : a_source_last;
    assign busy        = sel ? b_busy        : a_busy;
    assign err_len     = sel ? b_err_len     : a_err_len;
    assign source_d    = sel ? b_source_d    : a_source_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({sink_ack, wdat_ack, source_stb, source_last, busy, err_len, source_d});
    endfunction

    // Runs one command; records transferred bytes, optional stall and mid-frame reset
    task automatic do_frame(input logic wr, input logic [31:0] a, input logic [7:0] len,
                            input int stall_idx, input int stall_n, input logic [7:0] stall_exp,
                            input int abort_idx, input bit hold_cmd);
        int  stalls;
        int  widx;
        bit  done;
        bit  started;
        bit  aborted;
        got_q.delete();
        n_wack = 0; n_sack = 0; bubbles = 0; last_idx = -1;
        stalls = 0; widx = 0; done = 0; started = 0; aborted = 0;
        @(negedge clk);
        sink_wr = wr; sink_a = a; sink_len = len; sink_stb = 1'b1;
        wdat_stb = 1'b1; source_ack = 1'b1;
        wdat_d = (wdat_arr.size() > 0) ? wdat_arr[0] : 8'h00;
        for (int cyc = 0; cyc < 1200 && !done; cyc++) begin
            @(posedge clk); #1;
            if (sink_ack) begin
                n_sack++;
                check("hdr_after_ack", 32'({source_stb, source_d}), 32'({1'b1, 8'h55}));
                if (!hold_cmd) sink_stb = 1'b0;
            end
            if (wdat_ack) begin
                n_wack++;
                widx++;
                if (widx < wdat_arr.size()) wdat_d = wdat_arr[widx];
            end
            if (abort_idx >= 0 && source_stb && got_q.size() == abort_idx) begin
                #2 rst = 1'b1;
                #1 check("rst_async_outs", outs_vec(), 32'h0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                done = 1'b1;
            end else if (source_stb) begin
                started = 1'b1;
                if (got_q.size() == stall_idx && stalls < stall_n) begin
                    source_ack = 1'b0;
                    stalls++;
                    check("stall_hold_d", 32'({source_stb, source_d}), 32'({1'b1, stall_exp}));
                end else begin
                    source_ack = 1'b1;
                    got_q.push_back(source_d);
                    if (source_last) begin
                        last_idx = got_q.size() - 1;
                        done = 1'b1;
                    end
                end
            end else if (started) begin
                bubbles++;
            end
        end
        check("frame_done", 32'(done), 32'h1);
        if (!aborted) begin
            @(posedge clk); #1;
            check("idle_after_frame", 32'({busy, source_stb, source_last}), 32'h0);
        end
        source_ack = 1'b0;
        wdat_stb   = 1'b0;
        if (!hold_cmd) sink_stb = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp_q[$]);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check({tag, "_last_pos"}, 32'(last_idx), 32'(exp_q.size() - 1));
    endtask

    initial begin
        logic [7:0] e[$];
        n_tests = 0; n_fail = 0;
        rst = 1'b1; sel = 1'b0;
        sink_stb = 1'b0; sink_wr = 1'b0; sink_a = 32'h0; sink_len = 8'h0;
        wdat_stb = 1'b0; wdat_d = 8'h0; source_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_a", outs_vec(), 32'h0);
        sel = 1'b1;
        #1 check("reset_b", outs_vec(), 32'h0);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Write, a=0x1234, one data byte
        wdat_arr = '{8'hAB};
        do_frame(1'b1, 32'h1234, 8'd0, -1, 0, 8'h00, -1, 1'b0);
        e = '{8'h55, 8'h92, 8'h34, 8'h00, 8'hAB};
`ifdef BUS_ENCODE_BURST_CKSUM_EN
        e.push_back(8'hC6);
`endif
        check_frame("wr1", e);
        check("wr1_wack", 32'(n_wack), 32'd1);
        check("wr1_bubbles", 32'(bubbles), 32'd1);

        // Read, a=0x0010, len=3
        wdat_arr.delete();
        do_frame(1'b0, 32'h0010, 8'd3, -1, 0, 8'h00, -1, 1'b0);
        e = '{8'h55, 8'h00, 8'h10, 8'h03};
`ifdef BUS_ENCODE_BURST_CKSUM_EN
        e.push_back(8'h68);
`endif
        check_frame("rd", e);
        check("rd_wack", 32'(n_wack), 32'd0);
        check("rd_bubbles", 32'(bubbles), 32'd0);

        // Reject len+1 > MAX_LEN
        @(negedge clk);
        sink_wr = 1'b1; sink_len = 8'd16; sink_stb = 1'b1;
        @(posedge clk); #1;
        check("rej_pulse", 32'({sink_ack, err_len, busy, source_stb}), 32'b1100);
        sink_stb = 1'b0;
        @(posedge clk); #1;
        check("rej_after", 32'({sink_ack, err_len, busy, source_stb}), 32'b0000);

        // Largest accepted length on the default instance
        do_frame(1'b0, 32'h0000, 8'd15, -1, 0, 8'h00, -1, 1'b0);
        e = '{8'h55, 8'h00, 8'h00, 8'h0F};
`ifdef BUS_ENCODE_BURST_CKSUM_EN
        e.push_back(8'h64);
`endif
        check_frame("rd15", e);

        // Backpressure on second address byte
        wdat_arr = '{8'hAB};
        do_frame(1'b1, 32'h1234, 8'd0, 2, 5, 8'h34, -1, 1'b0);
        e = '{8'h55, 8'h92, 8'h34, 8'h00, 8'hAB};
`ifdef BUS_ENCODE_BURST_CKSUM_EN
        e.push_back(8'hC6);
`endif
        check_frame("bp", e);

        // Wide address instance
        sel = 1'b1;
        wdat_arr = '{8'h01, 8'h02};
        do_frame(1'b1, 32'h3ABCDE, 8'd1, -1, 0, 8'h00, -1, 1'b0);
        e = '{8'h55, 8'hBA, 8'hBC, 8'hDE, 8'h01, 8'h01, 8'h02};
`ifdef BUS_ENCODE_BURST_CKSUM_EN
        e.push_back(8'hAD);
`endif
        check_frame("w22", e);
        check("w22_wack", 32'(n_wack), 32'd2);
        check("w22_bubbles", 32'(bubbles), 32'd2);

        // Maximum 256-byte burst
        wdat_arr.delete();
        for (int i = 0; i < 256; i++) wdat_arr.push_back(8'(i));
        do_frame(1'b1, 32'h0, 8'd255, -1, 0, 8'h00, -1, 1'b0);
        e = '{8'h55, 8'h80, 8'h00, 8'h00, 8'hFF};
        for (int i = 0; i < 256; i++) e.push_back(8'(i));
`ifdef BUS_ENCODE_BURST_CKSUM_EN
        e.push_back(8'h54);
`endif
        check_frame("max", e);
        check("max_wack", 32'(n_wack), 32'd256);
        sel = 1'b0;

        // Held command: one accept during the frame, next accept right after
        wdat_arr.delete();
        do_frame(1'b0, 32'h0010, 8'd3, -1, 0, 8'h00, -1, 1'b1);
        check("hold_one_ack", 32'(n_sack), 32'd1);
        @(posedge clk); #1;
        check("hold_reaccept", 32'({sink_ack, busy}), 32'b11);
        sink_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset during the data byte, then the same command again
        wdat_arr = '{8'hAB};
        do_frame(1'b1, 32'h1234, 8'd0, -1, 0, 8'h00, 4, 1'b0);
        @(posedge clk); #1;
        check("post_abort_idle", outs_vec(), 32'h0);
        do_frame(1'b1, 32'h1234, 8'd0, -1, 0, 8'h00, -1, 1'b0);
        e = '{8'h55, 8'h92, 8'h34, 8'h00, 8'hAB};
`ifdef BUS_ENCODE_BURST_CKSUM_EN
        e.push_back(8'hC6);
`endif
        check_frame("rerun", e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_encode_burst.md
BUS_ENCODE_BURST -- requirements
Module: bus_encode_burst

Interface
REQ-001 Parameter ADDR_W, default 14, address width in bits; legal range 6..30.
REQ-002 Parameter MAX_LEN, default 16, maximum data bytes per frame; legal range 1..256.
REQ-003 Derived constant NAB = ceil((ADDR_W+2)/8), the number of address bytes per frame (2 at default).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 sink_stb  in  1  command valid.
REQ-007 sink_ack  out  1  one-cycle command accept pulse.
REQ-008 sink_wr  in  1  1 = write, 0 = read.
REQ-009 sink_a  in  ADDR_W  start address.
REQ-010 sink_len  in  8  byte count minus 1.
REQ-011 wdat_stb  in  1  write-data byte valid.
REQ-012 wdat_ack  out  1  one-cycle write-data accept pulse.
REQ-013 wdat_d  in  8  write-data byte.
REQ-014 source_stb  out  1  output byte valid.
REQ-015 source_ack  in  1  output byte taken by the sink.
REQ-016 source_d  out  8  output byte.
REQ-017 source_last  out  1  marks the final byte of a frame.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 err_len  out  1  one-cycle pulse when a command is rejected.

Function
REQ-020 A byte transfers on a rising edge where source_stb and source_ack are both 1; source_d and source_last shall hold stable while source_stb=1 and source_ack=0.
REQ-021 All outputs shall be registered; no combinational path from any input to any output.
REQ-022 States: IDLE, HEADER, ADDR, LEN, DFETCH, DATA, CKSUM.
- IDLE: when sink_stb=1, pulse sink_ack, latch wr/a/len, and clear the checksum accumulator.
- If sink_len+1 > MAX_LEN: pulse err_len in the same cycle as sink_ack and remain in IDLE.
- Otherwise go to HEADER.
REQ-023 HEADER: present 0x55.
REQ-024 ADDR: present NAB bytes, most significant first.
- First byte = {wr, 1'b0, remaining address MSBs, zero-extended}.
- Following bytes = successive 8-bit address slices.
- A byte counter wraps to LEN after the last address byte transfers.
REQ-025 LEN: present the latched len.
- After transfer: go to DFETCH for a write, or to CKSUM for a read.
- Reads carry no data bytes.
REQ-026 DFETCH: source_stb=0; when wdat_stb=1, pulse wdat_ack, capture wdat_d, and go to DATA.
REQ-027 DATA: present the captured byte.
- After transfer: return to DFETCH until len+1 bytes have been sent, then go to CKSUM.
REQ-028 CKSUM: present the 8-bit modulo-256 sum of every preceding frame byte (0x55 included), with source_last=1; after transfer go to IDLE.
REQ-029 Each state transition takes effect one cycle after the qualifying transfer.
- The first header byte is visible the cycle after sink_ack.
- source_stb stays high across consecutive non-DFETCH bytes with no bubble.
REQ-030 While busy=1, sink_ack shall stay 0; a held sink_stb is accepted on the first IDLE cycle after the frame ends.
REQ-031 sink_len=255 with MAX_LEN=256 shall produce exactly 256 data bytes; the byte counter shall not overflow.

Reset
REQ-032 On rst=1, independent of clk, the block shall:
- return to IDLE;
- drive sink_ack, wdat_ack, source_stb, source_last, busy and err_len to 0;
- drive source_d to 0x00;
- clear the counters and the checksum.
REQ-033 Reset mid-frame shall abort the frame with no resumption; a new command restarts at HEADER.

Configuration
REQ-034 Macro BUS_ENCODE_BURST_CKSUM_EN.
- Defined: the CKSUM byte is sent as in REQ-028.
- Undefined: the CKSUM state is removed and source_last is asserted on the final byte (last DATA byte for writes, LEN byte for reads).

Verification
REQ-035 Write: wr=1, a=0x1234, len=0, data 0xAB, source_ack=1 -> bytes 55 92 34 00 AB C6; last on C6; one wdat_ack pulse.
REQ-036 Read: wr=0, a=0x0010, len=3 -> bytes 55 00 10 03 68; zero wdat_ack pulses.
REQ-037 Reject: MAX_LEN=16, len=16 -> sink_ack and err_len both pulse in the same cycle; source_stb stays 0; busy stays 0.
REQ-038 Backpressure: hold source_ack=0 for 5 cycles on the second address byte -> source_d=0x34 stays stable with source_stb=1; the frame completes unchanged.
REQ-039 ADDR_W=22, write, a=0x3ABCDE, len=1, data 01 02 -> bytes 55 BA BC DE 01 01 02 followed by the checksum byte.
REQ-040 Assert rst during the DATA byte of REQ-035 -> all outputs 0 in the same cycle; repeating the command yields the identical frame.
